// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit core: opcodes, instruction field
// positions, the NOP encoding and the instruction-form classifier.
package cpu8_pkg;

  localparam logic [3:0]  OP_NOP    = 4'h0;
  localparam logic [3:0]  OP_LOAD   = 4'h7;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    FORM_NOP,
    FORM_REG,
    FORM_LOAD,
    FORM_IMM
  } form_e;

  function automatic form_e decode_form(input logic [3:0] op);
    if (op == OP_NOP)       return FORM_NOP;
    else if (op == OP_LOAD) return FORM_LOAD;
    else if (op[3])         return FORM_IMM;
    else                    return FORM_REG;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX result beats MEM result beats register file.
// Register 0 reads as zero and is never forwarded.
module fwd_mux #(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        src,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              ex_wr_en,
  input  logic [2:0]        ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] val
);

  always_comb begin
    val = rf_val;
    if (src == 3'd0)
      val = '0;
    else if (ex_wr_en && (ex_addr == src))
      val = ex_data;
    else if (mem_wr_en && (mem_addr == src))
      val = mem_data;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: field decode, register read addressing, operand forwarding,
// load-use interlock and the registered decode/execute latch.
module id_stage
  import cpu8_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [7:0]         pc_i,
  output logic               stall_o,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic [2:0]         rf_addr_a_o,
  output logic [2:0]         rf_addr_b_o,
  input  logic [DATA_W-1:0]  rf_a_i,
  input  logic [DATA_W-1:0]  rf_b_i,
  input  logic               ex_wr_en_i,
  input  logic [2:0]         ex_wr_addr_i,
  input  logic [DATA_W-1:0]  ex_data_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wr_en_i,
  input  logic [2:0]         mem_wr_addr_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  output logic               valid_o,
  output logic [3:0]         op_o,
  output logic [2:0]         dst_o,
  output logic               wr_en_o,
  output logic               is_load_o,
  output logic [DATA_W-1:0]  opa_o,
  output logic [DATA_W-1:0]  opb_o,
  output logic [7:0]         pc_o,
  output logic [7:0]         stall_cnt_o
);

  logic [3:0]        op;
  logic [2:0]        rd, ra, rb, src_a, src_b;
  logic [7:0]        imm8;
  form_e             form;
  logic [DATA_W-1:0] fwd_a, fwd_b, opb_d;
  logic              hazard;

  assign op   = instr_i[OP_MSB:OP_LSB];
  assign rd   = instr_i[RD_MSB:RD_LSB];
  assign ra   = instr_i[RA_MSB:RA_LSB];
  assign rb   = instr_i[RB_MSB:RB_LSB];
  assign imm8 = instr_i[IMM_MSB:IMM_LSB];
  assign form = decode_form(op);

  // Unused sources are address 0, which also keeps them out of hazard detection.
  always_comb begin
    src_a = 3'd0;
    src_b = 3'd0;
    case (form)
      FORM_REG:  begin src_a = ra; src_b = rb; end
      FORM_LOAD: src_a = ra;
      FORM_IMM:  src_a = rd;
      default:   ;
    endcase
  end

  assign rf_addr_a_o = src_a;
  assign rf_addr_b_o = src_b;

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .src(src_a), .rf_val(rf_a_i),
    .ex_wr_en(ex_wr_en_i), .ex_addr(ex_wr_addr_i), .ex_data(ex_data_i),
    .mem_wr_en(mem_wr_en_i), .mem_addr(mem_wr_addr_i), .mem_data(mem_data_i),
    .val(fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .src(src_b), .rf_val(rf_b_i),
    .ex_wr_en(ex_wr_en_i), .ex_addr(ex_wr_addr_i), .ex_data(ex_data_i),
    .mem_wr_en(mem_wr_en_i), .mem_addr(mem_wr_addr_i), .mem_data(mem_data_i),
    .val(fwd_b)
  );

  assign opb_d = (form == FORM_IMM) ? DATA_W'(imm8) : fwd_b;

  assign hazard = in_valid_i && ex_is_load_i && ex_wr_en_i && (ex_wr_addr_i != 3'd0) &&
                  ((ex_wr_addr_i == src_a) || (ex_wr_addr_i == src_b));

  assign stall_o = !flush_i && (hold_i || hazard);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!hold_i && hazard)) begin
      valid_o   <= 1'b0;
      op_o      <= '0;
      dst_o     <= '0;
      wr_en_o   <= 1'b0;
      is_load_o <= 1'b0;
      opa_o     <= '0;
      opb_o     <= '0;
      pc_o      <= '0;
    end else if (!hold_i) begin
      valid_o   <= in_valid_i;
      op_o      <= op;
      dst_o     <= rd;
      wr_en_o   <= in_valid_i && (form != FORM_NOP);
      is_load_o <= in_valid_i && (form == FORM_LOAD);
      opa_o     <= fwd_a;
      opb_o     <= opb_d;
      pc_o      <= pc_i;
    end
  end

  // Only interlock cycles count; hold and flush cycles are not hazard stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (!flush_i && !hold_i && hazard && (stall_cnt_o != 8'hFF))
      stall_cnt_o <= stall_cnt_o + 8'd1;
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected latch
// contents, a negedge monitor pops and compares whenever a new valid appears.
module tb_id_stage;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dst;
    logic       wr_en;
    logic       is_load;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, hold;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        stall;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [7:0]  rf_a, rf_b;
  logic        ex_wr_en, ex_is_load, mem_wr_en;
  logic [2:0]  ex_wr_addr, mem_wr_addr;
  logic [7:0]  ex_data, mem_data;
  logic        valid;
  logic [3:0]  op;
  logic [2:0]  dst;
  logic        wr_en, is_load;
  logic [7:0]  opa, opb, pc_q, stall_cnt;

  logic [7:0] rf [8];
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       accepted_last = 1'b0;

  always #5 clk = ~clk;

  assign rf_a = rf[rf_addr_a];
  assign rf_b = rf[rf_addr_b];

  id_stage #(.DATA_W(8), .INSTR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .instr_i(instr), .pc_i(pc),
    .stall_o(stall), .flush_i(flush), .hold_i(hold),
    .rf_addr_a_o(rf_addr_a), .rf_addr_b_o(rf_addr_b), .rf_a_i(rf_a), .rf_b_i(rf_b),
    .ex_wr_en_i(ex_wr_en), .ex_wr_addr_i(ex_wr_addr), .ex_data_i(ex_data),
    .ex_is_load_i(ex_is_load),
    .mem_wr_en_i(mem_wr_en), .mem_wr_addr_i(mem_wr_addr), .mem_data_i(mem_data),
    .valid_o(valid), .op_o(op), .dst_o(dst), .wr_en_o(wr_en), .is_load_o(is_load),
    .opa_o(opa), .opb_o(opb), .pc_o(pc_q), .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A new latch value appears only after an edge that was not held or reset.
  always @(posedge clk) accepted_last = !rst && !hold;

  always @(negedge clk) begin
    if (accepted_last && valid) begin
      exp_t e;
      exp_t a;
      a = '{op, dst, wr_en, is_load, opa, opb, pc_q};
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got %0h expected none", a);
      end else begin
        e = sb_q.pop_front();
        check("latch", a, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [7:0] p);
    in_valid = v;
    instr    = i;
    pc       = p;
  endtask

  task automatic clear_fwd();
    ex_wr_en = 0; ex_wr_addr = 0; ex_data = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_data = 0;
  endtask

  task automatic check_zero_latch(input string name);
    check(name, {valid, op, dst, wr_en, is_load, opa, opb, pc_q, stall_cnt}, '0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'(i * 8'h11);
    rf[0] = 8'h00; rf[1] = 8'h05; rf[2] = 8'h03; rf[3] = 8'h07;
    rst = 1; flush = 1; hold = 1;
    clear_fwd();
    drive(1, 16'h1298, 8'h10);
    tick(); tick();
    check_zero_latch("reset_outputs");
    rst = 0; flush = 0; hold = 0;

    // Register form, plain register-file operands
    drive(1, 16'h1298, 8'h10);
    #1;
    check("rf_addr_a", rf_addr_a, 3'd2);
    check("rf_addr_b", rf_addr_b, 3'd3);
    check("stall_idle", stall, 0);
    sb_q.push_back('{4'h1, 3'd1, 1'b1, 1'b0, 8'h03, 8'h07, 8'h10});
    tick();

    // EX beats MEM
    ex_wr_en = 1; ex_wr_addr = 2; ex_data = 8'hAA;
    mem_wr_en = 1; mem_wr_addr = 2; mem_data = 8'h55;
    drive(1, 16'h1298, 8'h11);
    sb_q.push_back('{4'h1, 3'd1, 1'b1, 1'b0, 8'hAA, 8'h07, 8'h11});
    tick();

    // MEM forward on B only
    clear_fwd();
    mem_wr_en = 1; mem_wr_addr = 3; mem_data = 8'h55;
    drive(1, 16'h1298, 8'h12);
    sb_q.push_back('{4'h1, 3'd1, 1'b1, 1'b0, 8'h03, 8'h55, 8'h12});
    tick();

    // r0 never forwarded
    clear_fwd();
    ex_wr_en = 1; ex_wr_addr = 0; ex_data = 8'hFF;
    drive(1, 16'h1218, 8'h13);
    #1;
    check("rf_addr_a_r0", rf_addr_a, 3'd0);
    sb_q.push_back('{4'h1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h07, 8'h13});
    tick();

    // Immediate form, then LOAD form
    clear_fwd();
    drive(1, 16'h845A, 8'h14);
    #1;
    check("rf_addr_a_imm", rf_addr_a, 3'd2);
    sb_q.push_back('{4'h8, 3'd2, 1'b1, 1'b0, 8'h03, 8'h5A, 8'h14});
    tick();
    drive(1, 16'h7840, 8'h15);
    #1;
    check("rf_addr_b_load", rf_addr_b, 3'd0);
    sb_q.push_back('{4'h7, 3'd4, 1'b1, 1'b1, 8'h05, 8'h00, 8'h15});
    tick();

    // NOP, then invalid slot
    drive(1, 16'h0000, 8'h16);
    sb_q.push_back('{4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h16});
    tick();
    drive(0, 16'h1298, 8'h17);
    tick();
    check("invalid_slot", {valid, wr_en, is_load}, 3'b000);

    // Load-use interlock: one bubble, then issue with MEM-forwarded value
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 2; ex_data = 8'h44;
    drive(1, 16'h1298, 8'h18);
    #1;
    check("stall_hazard", stall, 1);
    tick();
    check("bubble_valid", {valid, wr_en}, 2'b00);
    clear_fwd();
    mem_wr_en = 1; mem_wr_addr = 2; mem_data = 8'h99;
    #1;
    check("stall_released", stall, 0);
    sb_q.push_back('{4'h1, 3'd1, 1'b1, 1'b0, 8'h99, 8'h07, 8'h18});
    tick();
    check("stall_cnt_one", stall_cnt, 8'd1);

    // Flush dominates a hazard
    clear_fwd();
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 2;
    flush = 1;
    #1;
    check("stall_flush", stall, 0);
    tick();
    check("flush_valid", valid, 0);
    check("stall_cnt_flush", stall_cnt, 8'd1);
    flush = 0;
    clear_fwd();

    // Hold keeps the latch, then releases
    drive(1, 16'h845A, 8'h20);
    sb_q.push_back('{4'h8, 3'd2, 1'b1, 1'b0, 8'h03, 8'h5A, 8'h20});
    tick();
    hold = 1;
    drive(1, 16'h7840, 8'h21);
    #1;
    check("stall_hold", stall, 1);
    tick(); tick();
    check("hold_keep", {valid, op, opb, pc_q}, {1'b1, 4'h8, 8'h5A, 8'h20});
    flush = 1;
    #1;
    check("stall_hold_flush", stall, 0);
    tick();
    check("hold_flush_valid", valid, 0);
    flush = 0; hold = 0;
    sb_q.push_back('{4'h7, 3'd4, 1'b1, 1'b1, 8'h05, 8'h00, 8'h21});
    tick();

    // Saturation of the stall counter
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 2;
    drive(1, 16'h1298, 8'h30);
    for (int i = 0; i < 253; i++) tick();
    check("stall_cnt_fe", stall_cnt, 8'hFE);
    for (int i = 0; i < 47; i++) tick();
    check("stall_cnt_sat", stall_cnt, 8'hFF);

    // Reset mid-stall discards the instruction; stall_o follows inputs
    rst = 1; flush = 1; hold = 1;
    tick();
    check_zero_latch("reset_midstall");
    rst = 0; flush = 0; hold = 0;
    #1;
    check("stall_after_reset", stall, 1);
    clear_fwd();
    drive(0, 16'h0000, 8'h00);
    tick(); tick();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
